if_fetch_unit: RTL and testbench

Instruction-fetch front end of the five-stage RISC-V core inside `sopc`. It owns the program counter, issues word reads to the synchronous instruction ROM, and buffers returned instructions with their PCs in a 2-entry queue. The decode stage consumes the queue through a valid/ready handshake. It sits between the instruction ROM (upstream) and the IF/ID boundary (downstream), and accepts branch redirects from execute.

---
 rtl/if_fetch_unit_pkg.sv | 24 ++
 rtl/if_fetch_unit_fetch_queue.sv | 65 ++++++
 rtl/if_fetch_unit.sv | 117 +++++++++++
 tb/tb_if_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared RISC-V core definitions used by the fetch front end and its queue.
package riscv_defs;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] ZERO_WORD        = 32'h0;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int QUEUE_DEPTH = 2;

  // One buffered fetch result: the address it came from and the word returned.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned, so the low two address bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Two-entry synchronous FIFO holding {pc, inst} pairs between fetch and decode.
// Flush wins over push and pop; a push and pop in the same cycle on a full
// queue keeps it full with the new entry at the tail.
module fetch_queue
  import riscv_defs::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_data_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t entryQ_q [QUEUE_DEPTH];
  fetch_entry_t entryQ_d [QUEUE_DEPTH];
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic [1:0]   afterPop;

  // Next queue contents: apply the pop (shift toward the head) first, then
  // write the pushed entry into the first free slot that remains.
  always_comb begin
    entryQ_d = entryQ_q;
    count_d  = count_q;
    afterPop = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop_i && (count_q != 2'd0)) begin
        entryQ_d[0] = entryQ_q[1];
        afterPop    = count_q - 2'd1;
      end
      if (push_i && (afterPop < 2'd2)) begin
        entryQ_d[afterPop[0]] = push_data_i;
        count_d               = afterPop + 2'd1;
      end else begin
        count_d = afterPop;
      end
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 2'd0;
      entryQ_q[0] <= '0;
      entryQ_q[1] <= '0;
    end else begin
      count_q     <= count_d;
      entryQ_q[0] <= entryQ_d[0];
      entryQ_q[1] <= entryQ_d[1];
    end
  end

  assign count_o = count_q;
  assign head_o  = entryQ_q[0];

  // The issue credit guarantees a full queue is never pushed without a pop.
  noOverflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && !flush_i && (count_q == 2'd2)));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one-cycle-latency reads to
// the instruction ROM and buffers the results for decode in a 2-entry queue.
// Branch redirects from execute flush the queue and refetch from the target.
module if_fetch_unit
  import riscv_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [XLEN-1:0]   rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              branch_flag_i,
  input  logic [XLEN-1:0]   branch_target_i,
  input  logic              id_ready_i,
  output logic              id_valid_o,
  output logic [XLEN-1:0]   id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            inflight_q;
  logic            inflight_d;
  logic [XLEN-1:0] inflightPc_q;
  logic [XLEN-1:0] inflightPc_d;
  logic            discard_q;
  logic            discard_d;

  logic [1:0]      queueCount;
  fetch_entry_t    queueHead;
  fetch_entry_t    pushEntry;
  logic            pop;
  logic            push;
  logic            seqIssue;
  logic            issue;
  logic [2:0]      occupancy;
  logic [XLEN-1:0] targetAligned;

  // Credit check and request generation: a sequential fetch is allowed only
  // while queued plus outstanding entries, after this cycle's pop, stay below
  // two; a redirect always issues its target in the same cycle.
  always_comb begin
    targetAligned = word_align(branch_target_i);
    pop           = id_valid_o && id_ready_i;
    occupancy     = {1'b0, queueCount} + {2'b00, inflight_q};
    seqIssue      = occupancy < (3'd2 + {2'b00, pop});
    issue         = !rst && (branch_flag_i || seqIssue);
    rom_ce_o      = issue;
    if (!issue) begin
      rom_addr_o = ZERO_WORD;
    end else if (branch_flag_i) begin
      rom_addr_o = targetAligned;
    end else begin
      rom_addr_o = pc_q;
    end
    push          = inflight_q && !discard_q && !branch_flag_i && !rst;
    pushEntry     = '{pc: inflightPc_q, inst: rom_data_i};
  end

  // Next PC and in-flight tracking; a redirect overrides sequential fetch.
  always_comb begin
    pc_d         = pc_q;
    inflight_d   = 1'b0;
    inflightPc_d = inflightPc_q;
    discard_d    = discard_q;
    if (branch_flag_i) begin
      pc_d         = targetAligned + PC_STEP;
      inflight_d   = 1'b1;
      inflightPc_d = targetAligned;
      discard_d    = 1'b0;
    end else if (seqIssue) begin
      pc_d         = pc_q + PC_STEP;
      inflight_d   = 1'b1;
      inflightPc_d = pc_q;
    end
  end

  // PC and in-flight state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= ZERO_WORD;
      discard_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      discard_q    <= discard_d;
    end
  end

  fetch_queue uQueue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (branch_flag_i),
    .push_data_i (pushEntry),
    .count_o     (queueCount),
    .head_o      (queueHead)
  );

  // Head of the queue is presented to decode, zeroed while empty.
  always_comb begin
    id_valid_o = (queueCount != 2'd0);
    id_pc_o    = id_valid_o ? queueHead.pc   : ZERO_WORD;
    id_inst_o  = id_valid_o ? queueHead.inst : ZERO_WORD;
  end

  // Redirects reissue in the same cycle and the ROM answers in one, so a
  // stale response can never be outstanding.
  noDiscard: assert property (@(posedge clk) disable iff (rst) !discard_q);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit: streaming, back-pressure, redirects,
// PC wrap-around and mid-stream reset, with hand-computed expected values.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        branchFlag;
  logic [31:0] branchTarget;
  logic        idReady;

  logic        romCe;
  logic [31:0] romAddr;
  logic [31:0] romData;
  logic        idValid;
  logic [31:0] idPc;
  logic [31:0] idInst;

  logic        romCeW;
  logic [31:0] romAddrW;
  logic [31:0] romDataW;
  logic        idValidW;
  logic [31:0] idPcW;
  logic [31:0] idInstW;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (romCe),
    .rom_addr_o      (romAddr),
    .rom_data_i      (romData),
    .branch_flag_i   (branchFlag),
    .branch_target_i (branchTarget),
    .id_ready_i      (idReady),
    .id_valid_o      (idValid),
    .id_pc_o         (idPc),
    .id_inst_o       (idInst)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (romCeW),
    .rom_addr_o      (romAddrW),
    .rom_data_i      (romDataW),
    .branch_flag_i   (branchFlag),
    .branch_target_i (branchTarget),
    .id_ready_i      (idReady),
    .id_valid_o      (idValidW),
    .id_pc_o         (idPcW),
    .id_inst_o       (idInstW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM models: each returns its own address one cycle later.
  always @(posedge clk) begin
    romData  <= romCe  ? romAddr  : 32'hBAD0_BAD0;
    romDataW <= romCeW ? romAddrW : 32'hBAD0_BAD0;
  end

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges; the caller releases it in its cycle 0.
  task automatic holdReset();
    rst          = 1'b1;
    branchFlag   = 1'b0;
    branchTarget = 32'h0;
    idReady      = 1'b1;
    nextCycle();
    nextCycle();
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    branchFlag   = 1'b0;
    branchTarget = 32'h0;
    idReady      = 1'b1;
    nextCycle();
    nextCycle();
    nextCycle();
    #1;
    checks++; if (romCe !== 1'b0) begin errors++; $display("[TB] FAIL reset_ce: got %b expected 0", romCe); end
    checks++; if (romAddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", romAddr); end
    checks++; if (idValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", idValid); end
    checks++; if (idPc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", idPc); end
    checks++; if (idInst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 0", idInst); end
    checks++; if (romCeW !== 1'b0) begin errors++; $display("[TB] FAIL reset_ce_wrap: got %b expected 0", romCeW); end
    checks++; if (idValidW !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_wrap: got %b expected 0", idValidW); end
  endtask

  task automatic test_stream();
    logic [31:0] expPc;
    holdReset();
    for (int k = 0; k < 8; k++) begin
      nextCycle();
      rst     = 1'b0;
      idReady = 1'b1;
      #1;
      expPc = (k >= 2) ? 32'(4 * (k - 2)) : 32'h0;
      checks++; if (romCe !== 1'b1) begin errors++; $display("[TB] FAIL stream_ce c%0d: got %b expected 1", k, romCe); end
      checks++; if (romAddr !== 32'(4 * k)) begin errors++; $display("[TB] FAIL stream_addr c%0d: got %h expected %h", k, romAddr, 32'(4 * k)); end
      checks++; if (idValid !== (k >= 2)) begin errors++; $display("[TB] FAIL stream_valid c%0d: got %b expected %b", k, idValid, (k >= 2)); end
      checks++; if (idPc !== expPc) begin errors++; $display("[TB] FAIL stream_pc c%0d: got %h expected %h", k, idPc, expPc); end
      checks++; if (idInst !== expPc) begin errors++; $display("[TB] FAIL stream_inst c%0d: got %h expected %h", k, idInst, expPc); end
    end
  endtask

  task automatic test_back_pressure();
    logic        expCe;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    holdReset();
    for (int k = 0; k < 13; k++) begin
      nextCycle();
      rst     = 1'b0;
      idReady = !((k >= 5) && (k <= 8));
      #1;
      expCe    = !((k >= 5) && (k <= 8));
      expAddr  = (k < 5) ? 32'(4 * k) : 32'(4 * (k - 4));
      expValid = (k >= 2);
      if (k < 2)       expPc = 32'h0;
      else if (k <= 5) expPc = 32'(4 * (k - 2));
      else if (k <= 8) expPc = 32'd12;
      else             expPc = 32'(4 * (k - 6));
      checks++; if (romCe !== expCe) begin errors++; $display("[TB] FAIL bp_ce c%0d: got %b expected %b", k, romCe, expCe); end
      if (expCe) begin
        checks++; if (romAddr !== expAddr) begin errors++; $display("[TB] FAIL bp_addr c%0d: got %h expected %h", k, romAddr, expAddr); end
      end
      checks++; if (idValid !== expValid) begin errors++; $display("[TB] FAIL bp_valid c%0d: got %b expected %b", k, idValid, expValid); end
      checks++; if (idPc !== expPc) begin errors++; $display("[TB] FAIL bp_pc c%0d: got %h expected %h", k, idPc, expPc); end
      checks++; if (idInst !== expPc) begin errors++; $display("[TB] FAIL bp_inst c%0d: got %h expected %h", k, idInst, expPc); end
    end
  endtask

  task automatic test_redirect();
    logic        expCe;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    holdReset();
    for (int k = 0; k < 12; k++) begin
      nextCycle();
      rst          = 1'b0;
      idReady      = (k < 5) || (k >= 8);
      branchFlag   = (k == 7);
      branchTarget = 32'h0000_0100;
      #1;
      expCe = 1'b1; expAddr = 32'h0; expValid = 1'b0; expPc = 32'h0;
      case (k)
        6:  begin expCe = 1'b0; expValid = 1'b1; expPc = 32'd12; end
        7:  begin expAddr = 32'h100; expValid = 1'b1; expPc = 32'd12; end
        8:  begin expAddr = 32'h104; end
        9:  begin expAddr = 32'h108; expValid = 1'b1; expPc = 32'h100; end
        10: begin expAddr = 32'h10C; expValid = 1'b1; expPc = 32'h104; end
        11: begin expAddr = 32'h110; expValid = 1'b1; expPc = 32'h108; end
        default: ;
      endcase
      if (k >= 6) begin
        checks++; if (romCe !== expCe) begin errors++; $display("[TB] FAIL redir_ce c%0d: got %b expected %b", k, romCe, expCe); end
        if (expCe) begin
          checks++; if (romAddr !== expAddr) begin errors++; $display("[TB] FAIL redir_addr c%0d: got %h expected %h", k, romAddr, expAddr); end
        end
        checks++; if (idValid !== expValid) begin errors++; $display("[TB] FAIL redir_valid c%0d: got %b expected %b", k, idValid, expValid); end
        checks++; if (idPc !== expPc) begin errors++; $display("[TB] FAIL redir_pc c%0d: got %h expected %h", k, idPc, expPc); end
        checks++; if (idInst !== expPc) begin errors++; $display("[TB] FAIL redir_inst c%0d: got %h expected %h", k, idInst, expPc); end
      end
    end
    branchFlag = 1'b0;
  endtask

  task automatic test_redirect_pop();
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    holdReset();
    for (int k = 0; k < 8; k++) begin
      nextCycle();
      rst          = 1'b0;
      idReady      = 1'b1;
      branchFlag   = (k == 4);
      branchTarget = 32'h0000_0203;
      #1;
      case (k)
        4:       begin expAddr = 32'h200; expValid = 1'b1; expPc = 32'd8;   end
        5:       begin expAddr = 32'h204; expValid = 1'b0; expPc = 32'h0;   end
        6:       begin expAddr = 32'h208; expValid = 1'b1; expPc = 32'h200; end
        7:       begin expAddr = 32'h20C; expValid = 1'b1; expPc = 32'h204; end
        default: begin expAddr = 32'(4 * k); expValid = (k >= 2); expPc = (k >= 2) ? 32'(4 * (k - 2)) : 32'h0; end
      endcase
      if (k >= 3) begin
        checks++; if (romCe !== 1'b1) begin errors++; $display("[TB] FAIL rpop_ce c%0d: got %b expected 1", k, romCe); end
        checks++; if (romAddr !== expAddr) begin errors++; $display("[TB] FAIL rpop_addr c%0d: got %h expected %h", k, romAddr, expAddr); end
        checks++; if (idValid !== expValid) begin errors++; $display("[TB] FAIL rpop_valid c%0d: got %b expected %b", k, idValid, expValid); end
        checks++; if (idPc !== expPc) begin errors++; $display("[TB] FAIL rpop_pc c%0d: got %h expected %h", k, idPc, expPc); end
        checks++; if (idInst !== expPc) begin errors++; $display("[TB] FAIL rpop_inst c%0d: got %h expected %h", k, idInst, expPc); end
      end
    end
    branchFlag = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] expAddr;
    logic [31:0] expPc;
    holdReset();
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      rst     = 1'b0;
      idReady = 1'b1;
      #1;
      expAddr = 32'hFFFF_FFF8 + 32'(4 * k);
      expPc   = (k >= 2) ? 32'hFFFF_FFF8 + 32'(4 * (k - 2)) : 32'h0;
      checks++; if (romCeW !== 1'b1) begin errors++; $display("[TB] FAIL wrap_ce c%0d: got %b expected 1", k, romCeW); end
      checks++; if (romAddrW !== expAddr) begin errors++; $display("[TB] FAIL wrap_addr c%0d: got %h expected %h", k, romAddrW, expAddr); end
      checks++; if (idValidW !== (k >= 2)) begin errors++; $display("[TB] FAIL wrap_valid c%0d: got %b expected %b", k, idValidW, (k >= 2)); end
      checks++; if (idPcW !== expPc) begin errors++; $display("[TB] FAIL wrap_pc c%0d: got %h expected %h", k, idPcW, expPc); end
      checks++; if (idInstW !== expPc) begin errors++; $display("[TB] FAIL wrap_inst c%0d: got %h expected %h", k, idInstW, expPc); end
    end
  endtask

  task automatic test_reset_midstream();
    logic        expCe;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    holdReset();
    for (int k = 0; k < 7; k++) begin
      nextCycle();
      rst     = (k == 2) || (k == 3);
      idReady = 1'b1;
      #1;
      expCe = 1'b1; expAddr = 32'h0; expValid = 1'b0; expPc = 32'h0;
      case (k)
        2: begin expCe = 1'b0; end
        3: begin expCe = 1'b0; end
        4: begin expAddr = 32'h0; end
        5: begin expAddr = 32'h4; end
        6: begin expAddr = 32'h8; expValid = 1'b1; expPc = 32'h0; end
        default: ;
      endcase
      if (k >= 2) begin
        checks++; if (romCe !== expCe) begin errors++; $display("[TB] FAIL rstmid_ce c%0d: got %b expected %b", k, romCe, expCe); end
        checks++; if (romAddr !== expAddr) begin errors++; $display("[TB] FAIL rstmid_addr c%0d: got %h expected %h", k, romAddr, expAddr); end
      end
      if (k >= 3) begin
        checks++; if (idValid !== expValid) begin errors++; $display("[TB] FAIL rstmid_valid c%0d: got %b expected %b", k, idValid, expValid); end
        checks++; if (idPc !== expPc) begin errors++; $display("[TB] FAIL rstmid_pc c%0d: got %h expected %h", k, idPc, expPc); end
        checks++; if (idInst !== expPc) begin errors++; $display("[TB] FAIL rstmid_inst c%0d: got %h expected %h", k, idInst, expPc); end
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    branchFlag   = 1'b0;
    branchTarget = 32'h0;
    idReady      = 1'b1;
    test_reset();
    test_stream();
    test_back_pressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
